dcs_rd_scheduler: RTL and testbench
===================================

Name: dcs_rd_scheduler

Overview:
- Round-robin scheduler for the shared DCS rx-FIFO read port. Owns `dcs_rd_addr` and steps it through the FEE client FIFO nodes and the SRU's own FIFO node.
- Polls each node's `dcs_rx_fifo_status` and drains one complete frame per node visit.
- Forwards frames to a single downstream LocalLink-style TX interface toward the UDP transmit path.
- Sits between the DCS client FIFO bank (read side, 40 MHz) and the DCS reply/transmit logic.

Parameters:
- FirstAddr, 6'd0, first FEE FIFO node address scanned.
- NumNodes, 6'd40, number of consecutive FEE nodes scanned (FirstAddr..FirstAddr+NumNodes-1).
- SruFifoAddr, 6'd41, SRU FIFO node, visited after the last FEE node in every round.
- SettleCycles, 2, cycles after an address change before status is sampled (mux settling).
- TimeoutCycles, 16'd4096, maximum idle cycles mid-frame without an accepted beat.
- MaxFrameLen, 11'd1500, maximum bytes per frame before forced abort.

Ports:
- gclk_40m  in  1  clock (same clock as `dcs_rd_clk`)
- reset_n  in  1  asynchronous active-low reset
- enable  in  1  scheduler run enable
- dcs_rd_addr  out  6  FIFO node select
- dcs_rx_fifo_status  in  4  status of addressed node; bit0 = at least one complete frame stored
- dcs_rd_sof_n  in  1  start of frame, active low
- dcs_rd_data_out  in  8  frame byte
- dcs_rd_eof_n  in  1  end of frame, active low
- dcs_rd_src_rdy_n  in  1  source beat valid, active low
- dcs_rd_dst_rdy_n  out  1  scheduler ready to accept beat, active low
- tx_sof_n  out  1  downstream start of frame, active low
- tx_data  out  8  downstream byte
- tx_eof_n  out  1  downstream end of frame, active low
- tx_src_rdy_n  out  1  downstream beat valid, active low
- tx_dst_rdy_n  in  1  downstream ready, active low
- frame_cnt  out  16  frames fully forwarded, wraps at 16'hFFFF->0
- abort_cnt  out  8  frames aborted, saturates at 8'hFF
- busy  out  1  high while not in IDLE

Behaviour:
- Reset (async, `reset_n`=0) values:
  - `dcs_rd_addr`=FirstAddr; `dcs_rd_dst_rdy_n`=1.
  - `tx_sof_n`=`tx_eof_n`=`tx_src_rdy_n`=1; `tx_data`=0.
  - Counters=0; `busy`=0; FSM=IDLE.
  - Reset mid-frame abandons the frame with no TX closure.
- A beat transfers on any edge with `src_rdy_n`=0 and `dst_rdy_n`=0 on the same interface.
- FSM states:
  - IDLE: `enable`=1 -> SETTLE.
  - SETTLE: counts SettleCycles with `dcs_rd_addr` stable, then -> POLL.
  - POLL: `status[0]`=1 -> XFER. Otherwise -> NEXT.
  - XFER: combinational pass-through, zero latency:
    - `tx_data`=`dcs_rd_data_out`, `tx_sof_n`=`dcs_rd_sof_n`, `tx_eof_n`=`dcs_rd_eof_n`.
    - `tx_src_rdy_n`=`dcs_rd_src_rdy_n`.
    - `dcs_rd_dst_rdy_n`=`tx_dst_rdy_n`.
    - Transferred beat with `eof_n`=0 -> increment `frame_cnt`, go to NEXT.
  - ABORT: drives `tx_data`=8'h00, `tx_eof_n`=0, `tx_src_rdy_n`=0, `tx_sof_n`=1, `dcs_rd_dst_rdy_n`=1. Holds until `tx_dst_rdy_n`=0, then increments `abort_cnt` and goes to NEXT.
  - NEXT: advances the address, then -> SETTLE if `enable`=1, else -> IDLE.
- Outside XFER and ABORT: all tx_* held inactive and `dcs_rd_dst_rdy_n`=1.
- XFER -> ABORT triggers (first beat is beat 1 of the frame):
  - beat 1 has `sof_n`=1;
  - any later beat has `sof_n`=0;
  - byte count reaches MaxFrameLen without eof;
  - idle counter reaches TimeoutCycles. The idle counter clears on every transferred beat; it counts only while `dcs_rd_src_rdy_n`=1.
- The offending beat is not forwarded: `dcs_rd_dst_rdy_n` is gated high when an sof violation is present.
- Downstream backpressure (`tx_dst_rdy_n`=1) does not advance the timeout. Backpressure alone never aborts.
- Address sequence: FirstAddr .. FirstAddr+NumNodes-1, then SruFifoAddr, then wrap to FirstAddr. One frame maximum per visit.
- `enable` deasserted mid-XFER: the frame completes, then -> IDLE. `dcs_rd_addr` keeps its next value.
- `busy`=1 in every state except IDLE.

Test Plan:
- After reset, `enable`=1 with all nodes empty -> `dcs_rd_addr` visits 0,1,..,39,41,0. Each address is held SettleCycles+2 cycles. No TX activity.
- Node 5 holds a 10-byte frame 8'h01..8'h0A, `tx_dst_rdy_n`=0 -> TX carries the identical 10 bytes with sof on byte 1 and eof on byte 10. `frame_cnt`=1, next addr=6.
- Same frame with `tx_dst_rdy_n` toggling every other cycle -> bytes are neither lost nor duplicated, no abort, `frame_cnt`=1.
- Node 41 source stalls after 3 bytes for 4096 cycles -> ABORT beat 8'h00 with eof. `abort_cnt`=1, next addr=FirstAddr.
- A 1500-byte frame without eof -> abort after 1500 transferred bytes. A second sof mid-frame -> immediate abort.
- `reset_n` pulsed low mid-XFER -> all outputs return to reset values at once, independent of the clock.

Source files
------------

// File: rtl/dcs_rd_scheduler_if.sv
// LocalLink-style byte stream: one beat moves on a clock edge where
// src_rdy_n and dst_rdy_n are both low.
//   master : drives sof_n, eof_n, data, src_rdy_n; receives dst_rdy_n
//   slave  : receives sof_n, eof_n, data, src_rdy_n; drives dst_rdy_n
interface dcs_rd_scheduler_if;
  logic       sof_n;
  logic       eof_n;
  logic [7:0] data;
  logic       src_rdy_n;
  logic       dst_rdy_n;

  modport master (output sof_n, eof_n, data, src_rdy_n, input dst_rdy_n);
  modport slave  (input sof_n, eof_n, data, src_rdy_n, output dst_rdy_n);
endinterface

// File: rtl/dcs_rd_scheduler.sv
// Round-robin scheduler for the shared DCS rx-FIFO read port. It steps
// dcs_rd_addr over the FEE FIFO nodes and then the SRU node, polls the
// addressed node's status and, if a frame is stored, passes exactly one frame
// through to the TX stream. Malformed, oversized or stalled frames are closed
// downstream with a single 8'h00 beat carrying eof.
//
// Ports
//   gclk_40m, reset_n      clock, asynchronous active-low reset
//   enable                 scheduler run enable
//   dcs_rd_addr            FIFO node select
//   dcs_rx_fifo_status     addressed node status, bit0 = frame available
//   rd   (slave)           rx-FIFO read stream
//   tx   (master)          stream toward the UDP transmit path
//   frame_cnt              frames fully forwarded (wraps)
//   abort_cnt              frames aborted (saturates)
//   busy                   high in every state except IDLE
//
// state  | meaning
// IDLE   | parked, waits for enable
// SETTLE | address just changed, waits for the read mux to settle
// POLL   | samples status bit0 of the addressed node
// XFER   | zero-latency pass-through of one frame rd -> tx
// ABORT  | emits the closing 8'h00/eof beat downstream
// NEXT   | advances the address, then SETTLE or IDLE
module dcs_rd_scheduler #(
  parameter logic [5:0]  FirstAddr     = 6'd0,
  parameter logic [5:0]  NumNodes      = 6'd40,
  parameter logic [5:0]  SruFifoAddr   = 6'd41,
  parameter int          SettleCycles  = 2,
  parameter logic [15:0] TimeoutCycles = 16'd4096,
  parameter logic [10:0] MaxFrameLen   = 11'd1500
) (
  input  logic                      gclk_40m,
  input  logic                      reset_n,
  input  logic                      enable,
  output logic [5:0]                dcs_rd_addr,
  input  logic [3:0]                dcs_rx_fifo_status,
  dcs_rd_scheduler_if.slave         rd,
  dcs_rd_scheduler_if.master        tx,
  output logic [15:0]               frame_cnt,
  output logic [7:0]                abort_cnt,
  output logic                      busy
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SETTLE = 3'd1;
  localparam logic [2:0] ST_POLL   = 3'd2;
  localparam logic [2:0] ST_XFER   = 3'd3;
  localparam logic [2:0] ST_ABORT  = 3'd4;
  localparam logic [2:0] ST_NEXT   = 3'd5;

  localparam logic [5:0] LastFeeAddr = 6'(FirstAddr + NumNodes - 6'd1);
  localparam logic [7:0] SettleLoad  = 8'(SettleCycles - 1);

  logic [2:0]  state;
  logic [7:0]  settle_cnt;
  logic [15:0] idle_left;
  logic [10:0] bytes_left;
  logic        first_beat;

  logic        in_xfer;
  logic        sof_err;
  logic        beat;
  logic        last_beat;
  logic        len_err;
  logic        idle_tick;
  logic        timeout;
  logic [5:0]  addr_nxt;

  logic        tx_sof_n;
  logic        tx_eof_n;
  logic        tx_src_rdy_n;
  logic [7:0]  tx_data;
  logic        rd_dst_rdy_n;

  logic        unused_status;
  assign unused_status = ^dcs_rx_fifo_status[3:1];

  assign in_xfer = (state == ST_XFER);

  // Beat 1 must carry sof and no later beat may. The violating beat is
  // refused on both sides so it never reaches the downstream stream.
  assign sof_err   = in_xfer && !rd.src_rdy_n && (first_beat ? rd.sof_n : !rd.sof_n);
  assign beat      = in_xfer && !rd.src_rdy_n && !rd_dst_rdy_n;
  assign last_beat = beat && !rd.eof_n;
  assign len_err   = beat && rd.eof_n && (bytes_left == 11'd1);
  // Only an absent source counts as idle; downstream backpressure does not.
  assign idle_tick = in_xfer && rd.src_rdy_n;
  assign timeout   = idle_tick && (idle_left == 16'd1);

  always_comb begin
    if (dcs_rd_addr == SruFifoAddr) begin
      addr_nxt = FirstAddr;
    end else if (dcs_rd_addr == LastFeeAddr) begin
      addr_nxt = SruFifoAddr;
    end else begin
      addr_nxt = dcs_rd_addr + 6'd1;
    end
  end

  always_comb begin
    tx_sof_n     = 1'b1;
    tx_eof_n     = 1'b1;
    tx_src_rdy_n = 1'b1;
    tx_data      = 8'h00;
    rd_dst_rdy_n = 1'b1;
    case (state)
      ST_XFER: begin
        tx_sof_n     = rd.sof_n;
        tx_eof_n     = rd.eof_n;
        tx_data      = rd.data;
        tx_src_rdy_n = rd.src_rdy_n | sof_err;
        rd_dst_rdy_n = tx.dst_rdy_n | sof_err;
      end
      ST_ABORT: begin
        tx_eof_n     = 1'b0;
        tx_src_rdy_n = 1'b0;
      end
      default: ;
    endcase
  end

  assign tx.sof_n     = tx_sof_n;
  assign tx.eof_n     = tx_eof_n;
  assign tx.data      = tx_data;
  assign tx.src_rdy_n = tx_src_rdy_n;
  assign rd.dst_rdy_n = rd_dst_rdy_n;
  assign busy         = (state != ST_IDLE);

  always_ff @(posedge gclk_40m or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      dcs_rd_addr <= FirstAddr;
      settle_cnt  <= 8'd0;
      idle_left   <= 16'd0;
      bytes_left  <= 11'd0;
      first_beat  <= 1'b0;
      frame_cnt   <= 16'd0;
      abort_cnt   <= 8'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          settle_cnt <= SettleLoad;
          if (enable) state <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (settle_cnt == 8'd0) state <= ST_POLL;
          else                    settle_cnt <= settle_cnt - 8'd1;
        end
        ST_POLL: begin
          first_beat <= 1'b1;
          idle_left  <= TimeoutCycles;
          bytes_left <= MaxFrameLen;
          state      <= dcs_rx_fifo_status[0] ? ST_XFER : ST_NEXT;
        end
        ST_XFER: begin
          if (beat) begin
            first_beat <= 1'b0;
            idle_left  <= TimeoutCycles;
            bytes_left <= bytes_left - 11'd1;
          end else if (idle_tick) begin
            idle_left <= idle_left - 16'd1;
          end
          if (sof_err || len_err || timeout) begin
            state <= ST_ABORT;
          end else if (last_beat) begin
            frame_cnt <= frame_cnt + 16'd1;
            state     <= ST_NEXT;
          end
        end
        ST_ABORT: begin
          if (!tx.dst_rdy_n) begin
            if (abort_cnt != 8'hFF) abort_cnt <= abort_cnt + 8'd1;
            state <= ST_NEXT;
          end
        end
        ST_NEXT: begin
          dcs_rd_addr <= addr_nxt;
          settle_cnt  <= SettleLoad;
          state       <= enable ? ST_SETTLE : ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcs_rd_scheduler.sv
// Bench for dcs_rd_scheduler: a FIFO-node source model feeds the read
// stream, expected TX beats are queued when a frame is loaded and popped by
// a monitor as the DUT emits them.
module tb_dcs_rd_scheduler;

  typedef struct packed {
    logic       sof_n;
    logic       eof_n;
    logic [7:0] data;
  } beat_t;

  typedef struct {
    logic [5:0] node;
    int         len;
    logic [7:0] base;
    bit         bp;
    int         bad_sof_at;
    logic [5:0] exp_next;
  } vec_t;

  logic        gclk_40m = 1'b0;
  logic        reset_n;
  logic        enable;
  logic [5:0]  dcs_rd_addr;
  logic [3:0]  dcs_rx_fifo_status;
  logic [15:0] frame_cnt;
  logic [7:0]  abort_cnt;
  logic        busy;

  dcs_rd_scheduler_if rd_if ();
  dcs_rd_scheduler_if tx_if ();

  dcs_rd_scheduler dut (
    .gclk_40m           (gclk_40m),
    .reset_n            (reset_n),
    .enable             (enable),
    .dcs_rd_addr        (dcs_rd_addr),
    .dcs_rx_fifo_status (dcs_rx_fifo_status),
    .rd                 (rd_if),
    .tx                 (tx_if),
    .frame_cnt          (frame_cnt),
    .abort_cnt          (abort_cnt),
    .busy               (busy)
  );

  initial forever #5 gclk_40m = ~gclk_40m;

  beat_t      src_q[$];
  beat_t      exp_q[$];
  logic [5:0] src_node = 6'd0;
  int         stall_after = 0;
  int         src_sent = 0;
  bit         bp_mode = 1'b0;
  int         n_vec = 0;
  int         n_bad = 0;
  int         cyc = 0;
  int         last_tx_cyc = 0;
  int         prev_tx_cyc = 0;
  int         tx_beats = 0;
  int         exp_frames = 0;
  int         exp_aborts = 0;
  vec_t       vecs[7];

  always @(posedge gclk_40m) cyc <= cyc + 1;

  // Source model: one FIFO node holding src_q, plus downstream ready pattern.
  initial begin
    bit fire;
    rd_if.sof_n        = 1'b1;
    rd_if.eof_n        = 1'b1;
    rd_if.data         = 8'h00;
    rd_if.src_rdy_n    = 1'b1;
    tx_if.dst_rdy_n    = 1'b0;
    dcs_rx_fifo_status = 4'h0;
    forever begin
      @(negedge gclk_40m);
      fire = !rd_if.src_rdy_n && !rd_if.dst_rdy_n;
      @(posedge gclk_40m);
      #1;
      if (fire && src_q.size() > 0) begin
        void'(src_q.pop_front());
        src_sent++;
      end
      if (src_q.size() == 0) src_sent = 0;
      tx_if.dst_rdy_n = bp_mode ? ~tx_if.dst_rdy_n : 1'b0;
      if (src_q.size() > 0 && !(stall_after != 0 && src_sent >= stall_after)) begin
        rd_if.sof_n     = src_q[0].sof_n;
        rd_if.eof_n     = src_q[0].eof_n;
        rd_if.data      = src_q[0].data;
        rd_if.src_rdy_n = 1'b0;
      end else begin
        rd_if.src_rdy_n = 1'b1;
      end
      dcs_rx_fifo_status = {3'b000, (dcs_rd_addr == src_node) && (src_q.size() > 0)};
    end
  end

  // TX monitor / scoreboard.
  initial begin
    beat_t got;
    beat_t want;
    forever begin
      @(negedge gclk_40m);
      if (reset_n && !tx_if.src_rdy_n && !tx_if.dst_rdy_n) begin
        got = {tx_if.sof_n, tx_if.eof_n, tx_if.data};
        prev_tx_cyc = last_tx_cyc;
        last_tx_cyc = cyc;
        tx_beats++;
        n_vec++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL tx_unexpected got sof_n/eof_n/data=%h required none", got);
        end else begin
          want = exp_q.pop_front();
          if (got !== want) begin
            n_bad++;
            $display("FAIL tx_beat got sof_n/eof_n/data=%h required %h", got, want);
          end
        end
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog expired at cycle %0d required finish", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s got %0h required %0h", name, act, req);
    end
  endtask

  task automatic load_src(input logic [5:0] node, input int len, input logic [7:0] base,
                          input int bad_sof_at, input bit with_eof);
    beat_t b;
    src_node = node;
    for (int i = 0; i < len; i++) begin
      b.sof_n = (i == 0) ? 1'b0 : 1'b1;
      if (bad_sof_at == 1 && i == 0) b.sof_n = 1'b1;
      if (bad_sof_at > 1 && i == bad_sof_at - 1) b.sof_n = 1'b0;
      b.eof_n = (with_eof && i == len - 1) ? 1'b0 : 1'b1;
      b.data  = base + 8'(i);
      src_q.push_back(b);
    end
  endtask

  // Expected TX: the first n_fwd source beats unchanged, then the abort beat.
  task automatic push_exp(input int n_fwd, input bit with_abort);
    for (int i = 0; i < n_fwd; i++) exp_q.push_back(src_q[i]);
    if (with_abort) exp_q.push_back({1'b1, 1'b0, 8'h00});
  endtask

  task automatic wait_drain(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge gclk_40m);
      if (exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_addr_change(input int budget, output logic [5:0] na);
    logic [5:0] old;
    old = dcs_rd_addr;
    na  = old;
    for (int i = 0; i < budget; i++) begin
      @(negedge gclk_40m);
      if (dcs_rd_addr !== old) begin
        na = dcs_rd_addr;
        break;
      end
    end
  endtask

  initial begin
    bit         ok;
    logic [5:0] na;
    logic [5:0] old;
    logic [5:0] exp_a;
    int         hold;
    int         n_fwd;
    bit         got;

    vecs[0] = '{6'd5,  10, 8'h01, 1'b0, 0, 6'd6};
    vecs[1] = '{6'd5,  10, 8'h01, 1'b1, 0, 6'd6};
    vecs[2] = '{6'd39,  4, 8'h30, 1'b0, 0, 6'd41};
    vecs[3] = '{6'd41,  1, 8'h55, 1'b1, 0, 6'd0};
    vecs[4] = '{6'd12,  8, 8'h70, 1'b0, 4, 6'd13};
    vecs[5] = '{6'd7,   5, 8'h90, 1'b1, 1, 6'd8};
    vecs[6] = '{6'd0,   3, 8'hC0, 1'b0, 0, 6'd1};

    reset_n = 1'b0;
    enable  = 1'b0;
    repeat (3) @(negedge gclk_40m);
    reset_n = 1'b1;
    @(negedge gclk_40m);

    check("rst_addr", dcs_rd_addr, 6'd0);
    check("rst_rd_dst_rdy_n", rd_if.dst_rdy_n, 1'b1);
    check("rst_tx_sof_n", tx_if.sof_n, 1'b1);
    check("rst_tx_eof_n", tx_if.eof_n, 1'b1);
    check("rst_tx_src_rdy_n", tx_if.src_rdy_n, 1'b1);
    check("rst_tx_data", tx_if.data, 8'h00);
    check("rst_frame_cnt", frame_cnt, 16'd0);
    check("rst_abort_cnt", abort_cnt, 8'd0);
    check("rst_busy", busy, 1'b0);

    // Empty sweep: 0..39, 41, 0 with each address held four cycles.
    enable = 1'b1;
    old = dcs_rd_addr;
    for (int k = 0; k < 41; k++) begin
      exp_a = (k < 39) ? 6'(k + 1) : ((k == 39) ? 6'd41 : 6'd0);
      hold = 0;
      got  = 1'b0;
      for (int c = 0; c < 20 && !got; c++) begin
        @(negedge gclk_40m);
        hold++;
        if (dcs_rd_addr !== old) got = 1'b1;
      end
      check($sformatf("sweep_addr%0d", k), dcs_rd_addr, exp_a);
      if (k > 0) check($sformatf("sweep_hold%0d", k), hold, 4);
      old = dcs_rd_addr;
    end
    check("sweep_no_tx", tx_beats, 0);
    check("sweep_busy", busy, 1'b1);

    // Table-driven frames.
    for (int v = 0; v < 7; v++) begin
      bp_mode = vecs[v].bp;
      load_src(vecs[v].node, vecs[v].len, vecs[v].base, vecs[v].bad_sof_at, 1'b1);
      n_fwd = (vecs[v].bad_sof_at == 0) ? vecs[v].len : vecs[v].bad_sof_at - 1;
      push_exp(n_fwd, vecs[v].bad_sof_at != 0);
      if (vecs[v].bad_sof_at == 0) exp_frames++;
      else                         exp_aborts++;
      wait_drain(3000, ok);
      check($sformatf("vec%0d_drained", v), ok, 1'b1);
      src_q.delete();
      wait_addr_change(50, na);
      check($sformatf("vec%0d_next_addr", v), na, vecs[v].exp_next);
      check($sformatf("vec%0d_frame_cnt", v), frame_cnt, exp_frames);
      check($sformatf("vec%0d_abort_cnt", v), abort_cnt, exp_aborts);
    end

    // Node 41 stalls after 3 bytes: abort after 4096 idle cycles.
    bp_mode     = 1'b0;
    stall_after = 3;
    load_src(6'd41, 8, 8'hA0, 0, 1'b1);
    push_exp(3, 1'b1);
    exp_aborts++;
    wait_drain(6000, ok);
    check("timeout_drained", ok, 1'b1);
    check("timeout_gap", last_tx_cyc - prev_tx_cyc, 4097);
    src_q.delete();
    stall_after = 0;
    wait_addr_change(50, na);
    check("timeout_next_addr", na, 6'd0);
    check("timeout_abort_cnt", abort_cnt, exp_aborts);
    check("timeout_frame_cnt", frame_cnt, exp_frames);

    // Frame without eof: 1500 bytes pass, then the abort beat.
    load_src(6'd20, 1502, 8'h00, 0, 1'b0);
    push_exp(1500, 1'b1);
    exp_aborts++;
    wait_drain(4000, ok);
    check("maxlen_drained", ok, 1'b1);
    src_q.delete();
    wait_addr_change(50, na);
    check("maxlen_next_addr", na, 6'd21);
    check("maxlen_abort_cnt", abort_cnt, exp_aborts);

    // enable dropped mid-frame: frame completes, then park with next address.
    bp_mode = 1'b1;
    load_src(6'd8, 6, 8'hE0, 0, 1'b1);
    push_exp(6, 1'b0);
    exp_frames++;
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge gclk_40m);
      if (exp_q.size() < 6) begin
        ok = 1'b1;
        break;
      end
    end
    check("en_started", ok, 1'b1);
    enable = 1'b0;
    wait_drain(1000, ok);
    check("en_drained", ok, 1'b1);
    wait_addr_change(50, na);
    check("en_next_addr", na, 6'd9);
    check("en_frame_cnt", frame_cnt, exp_frames);
    repeat (4) @(negedge gclk_40m);
    check("en_idle_busy", busy, 1'b0);
    check("en_idle_addr", dcs_rd_addr, 6'd9);

    // Reset pulsed mid-XFER: outputs return to reset values without a clock edge.
    enable = 1'b1;
    load_src(6'd3, 20, 8'h10, 0, 1'b1);
    push_exp(20, 1'b0);
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge gclk_40m);
      if (exp_q.size() <= 17) begin
        ok = 1'b1;
        break;
      end
    end
    check("rstx_started", ok, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    check("rstx_addr", dcs_rd_addr, 6'd0);
    check("rstx_rd_dst_rdy_n", rd_if.dst_rdy_n, 1'b1);
    check("rstx_tx_sof_n", tx_if.sof_n, 1'b1);
    check("rstx_tx_eof_n", tx_if.eof_n, 1'b1);
    check("rstx_tx_src_rdy_n", tx_if.src_rdy_n, 1'b1);
    check("rstx_tx_data", tx_if.data, 8'h00);
    check("rstx_frame_cnt", frame_cnt, 16'd0);
    check("rstx_abort_cnt", abort_cnt, 8'd0);
    check("rstx_busy", busy, 1'b0);
    exp_q.delete();
    src_q.delete();
    enable = 1'b0;
    repeat (2) @(posedge gclk_40m);
    @(negedge gclk_40m);
    reset_n = 1'b1;
    @(negedge gclk_40m);
    check("post_rst_busy", busy, 1'b0);
    check("post_rst_frame_cnt", frame_cnt, 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
